// File: rtl/snn_pkg.sv
// Shared types and defaults for the SNN frame controller slice.
package snn_pkg;

  localparam int NUM_PIXELS_DEF = 784;
  localparam int ADDR_W_DEF     = 10;
  localparam int WDOG_CYC_DEF   = 65535;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    RESULT = 2'd3
  } frame_state_t;

endpackage

// File: rtl/snn_bit_unpacker.sv
// Unpacks pixel bytes (bit0 first) into sequential 1-bit RAM writes.
// A new byte may be taken while the last bit of the previous one is being
// written, so a continuous byte stream produces one write per cycle.
module snn_bit_unpacker
  import snn_pkg::*;
#(
  parameter int NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              can_accept,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic              d,
  output logic              last_wr,
  output logic              active
);

  localparam int NUM_BYTES = NUM_PIXELS / 8;
  localparam int BC_W      = $clog2(NUM_BYTES + 1);
  localparam logic [BC_W-1:0]   NUM_BYTES_V = BC_W'(NUM_BYTES);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_PIXELS - 1);

  logic [7:0]        shifter_q, shifter_d;
  logic [3:0]        bits_left_q, bits_left_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic              accept;

  // Accept/write decode and next-state for the shifter and counters.
  always_comb begin
    shifter_d   = shifter_q;
    bits_left_d = bits_left_q;
    pix_cnt_d   = pix_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    can_accept  = en && (byte_cnt_q < NUM_BYTES_V) && (bits_left_q <= 4'd1);
    accept      = can_accept && rx_valid;
    we          = en && (bits_left_q != 4'd0);
    if (we) begin
      shifter_d   = {1'b0, shifter_q[7:1]};
      bits_left_d = bits_left_q - 4'd1;
      pix_cnt_d   = pix_cnt_q + 1'b1;
    end
    if (accept) begin
      shifter_d   = rx_data;
      bits_left_d = 4'd8;
      byte_cnt_d  = byte_cnt_q + 1'b1;
    end
    if (clr) begin
      shifter_d   = 8'd0;
      bits_left_d = 4'd0;
      pix_cnt_d   = '0;
      byte_cnt_d  = '0;
    end
  end

  // Shifter and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shifter_q   <= 8'd0;
      bits_left_q <= 4'd0;
      pix_cnt_q   <= '0;
      byte_cnt_q  <= '0;
    end else begin
      shifter_q   <= shifter_d;
      bits_left_q <= bits_left_d;
      pix_cnt_q   <= pix_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  assign addr    = pix_cnt_q;
  assign d       = shifter_q[0];
  assign last_wr = we && (pix_cnt_q == LAST_ADDR);
  assign active  = (byte_cnt_q != '0) || (bits_left_q != 4'd0);

endmodule

// File: rtl/snn_frame_ctrl.sv
// Frame sequencer: loads a bitmap into the input-unit RAM, starts the core,
// and returns its digit. Optional RUN watchdog enabled by SNN_WDOG_EN.
//
// Handshakes: a transfer happens on a posedge where valid & ready are both 1.
// rx_valid/rx_data are sampled only then; res_valid, once high, stays high
// with res_digit/res_err stable until a cycle with res_ready=1.
module snn_frame_ctrl
  import snn_pkg::*;
#(
  parameter int NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int WDOG_CYC   = WDOG_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_d,
  input  logic [ADDR_W-1:0] core_addr,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic [3:0]        res_digit,
  output logic              res_err,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output frame_state_t      dbg_state
);

  frame_state_t      state_q, state_d;
  logic [3:0]        res_digit_q, res_digit_d;
  logic              clr;
  logic              unp_we, unp_d, unp_last, unp_active, unp_ready;
  logic [ADDR_W-1:0] unp_addr;

`ifdef SNN_WDOG_EN
  localparam int WDOG_W = ($clog2(WDOG_CYC) > 0) ? $clog2(WDOG_CYC) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              res_err_q, res_err_d;
`else
  logic [31:0] unused_wdog_cyc;
  assign unused_wdog_cyc = WDOG_CYC;
`endif

  snn_bit_unpacker #(
    .NUM_PIXELS(NUM_PIXELS),
    .ADDR_W    (ADDR_W)
  ) u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .en        (state_q == LOAD),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .can_accept(unp_ready),
    .we        (unp_we),
    .addr      (unp_addr),
    .d         (unp_d),
    .last_wr   (unp_last),
    .active    (unp_active)
  );

  // Frame FSM next-state, start pulse, result capture and watchdog.
  always_comb begin
    state_d     = state_q;
    res_digit_d = res_digit_q;
    core_start  = 1'b0;
    clr         = 1'b0;
`ifdef SNN_WDOG_EN
    wdog_d      = wdog_q;
    res_err_d   = res_err_q;
`endif
    case (state_q)
      LOAD: begin
        if (unp_last) state_d = START;
      end
      START: begin
        core_start = 1'b1;
        state_d    = RUN;
`ifdef SNN_WDOG_EN
        wdog_d     = '0;
`endif
      end
      RUN: begin
`ifdef SNN_WDOG_EN
        wdog_d = wdog_q + 1'b1;
`endif
        if (core_done) begin
          res_digit_d = core_digit;
          state_d     = RESULT;
`ifdef SNN_WDOG_EN
          res_err_d   = 1'b0;
        end else if (wdog_q == WDOG_LAST) begin
          res_digit_d = 4'hF;
          res_err_d   = 1'b1;
          state_d     = RESULT;
`endif
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d = LOAD;
          clr     = 1'b1;
        end
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      res_digit_q <= 4'd0;
`ifdef SNN_WDOG_EN
      wdog_q      <= '0;
      res_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      res_digit_q <= res_digit_d;
`ifdef SNN_WDOG_EN
      wdog_q      <= wdog_d;
      res_err_q   <= res_err_d;
`endif
    end
  end

`ifdef SNN_WDOG_EN
  assign res_err = res_err_q;
`else
  assign res_err = 1'b0;
`endif

  assign rx_ready  = unp_ready;
  assign ram_we    = unp_we;
  assign ram_d     = unp_d;
  assign ram_addr  = (state_q == LOAD) ? unp_addr : core_addr;
  assign res_digit = res_digit_q;
  assign res_valid = (state_q == RESULT);
  assign busy      = (state_q != LOAD) || unp_active;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_snn_frame_ctrl.sv
// Directed bench for snn_frame_ctrl (watchdog branch under SNN_WDOG_EN).
module tb_snn_frame_ctrl;
  import snn_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic        ram_d;
  logic [9:0]  core_addr = 10'd0;
  logic        core_start;
  logic        core_done = 1'b0;
  logic [3:0]  core_digit = 4'd0;
  logic [3:0]  res_digit;
  logic        res_err;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_err = 0;

  logic [10:0] wr_q[$];
  logic [10:0] exp_q[$];
  int accept_cnt = 0;
  int start_cnt = 0;
  int cyc = 0;
  int start_cyc = -1;
  int last_wr_cyc = -100;

  snn_frame_ctrl #(
    .NUM_PIXELS(784),
    .ADDR_W    (10),
    .WDOG_CYC  (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_d     (ram_d),
    .core_addr (core_addr),
    .core_start(core_start),
    .core_done (core_done),
    .core_digit(core_digit),
    .res_digit (res_digit),
    .res_err   (res_err),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Mid-cycle monitor: records RAM writes, accepts and start pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) wr_q.push_back({ram_addr, ram_d});
      if (ram_we && ram_addr == 10'd783) last_wr_cyc = cyc;
      if (rx_valid && rx_ready) accept_cnt++;
      if (core_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Driver: present one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && t < 50) begin
      tick();
      t++;
    end
    chk("accept_wait", {31'd0, rx_ready}, 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_start(input int bound);
    int t;
    t = 0;
    while (!core_start && t < bound) begin
      tick();
      t++;
    end
    chk("start_pulse", {31'd0, core_start}, 32'd1);
  endtask

  task automatic compare_writes(input string tag);
    chk({tag, "_count"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      chk(tag, {21'd0, wr_q[i]}, {21'd0, exp_q[i]});
  endtask

  logic [7:0] gap_bytes [3];
  logic [7:0] byte_v;
  int n;

  initial begin
    gap_bytes = '{8'h3C, 8'h81, 8'hFF};

    // Reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_core_start", {31'd0, core_start}, 32'd0);
    chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_res_digit", {28'd0, res_digit}, 32'd0);
    chk("rst_res_err", {31'd0, res_err}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;

    // Frame 1: 98 x 0xA5 back-to-back, valid kept high afterwards
    for (int i = 0; i < 98; i++) send_byte(8'hA5);
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    wait_start(60);
    tick();
    chk("start_one_cycle", {31'd0, core_start}, 32'd0);
    repeat (5) tick();
    rx_valid = 1'b0;
    chk("frame1_accepts", accept_cnt, 98);
    chk("frame1_starts", start_cnt, 1);
    chk("start_after_last_wr", start_cyc, last_wr_cyc + 1);
    byte_v = 8'hA5;
    exp_q.delete();
    for (int i = 0; i < 784; i++) exp_q.push_back({10'(i), byte_v[i % 8]});
    compare_writes("frame1_wr");

    // RUN: address mux and result handshake
    core_addr = 10'h123;
    #1;
    chk("run_ram_addr", {22'd0, ram_addr}, 32'h123);
    chk("run_ram_we", {31'd0, ram_we}, 32'd0);
    chk("run_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("run_busy", {31'd0, busy}, 32'd1);
    chk("run_res_valid", {31'd0, res_valid}, 32'd0);
    core_done  = 1'b1;
    core_digit = 4'd7;
    tick();
    core_done  = 1'b0;
    core_digit = 4'd2;
    chk("res_valid_rise", {31'd0, res_valid}, 32'd1);
    chk("res_digit", {28'd0, res_digit}, 32'd7);
    chk("res_err_clear", {31'd0, res_err}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("res_hold_valid", {31'd0, res_valid}, 32'd1);
      chk("res_hold_digit", {28'd0, res_digit}, 32'd7);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("hs_res_valid", {31'd0, res_valid}, 32'd0);
    chk("hs_rx_ready", {31'd0, rx_ready}, 32'd1);
    chk("hs_state", {30'd0, dbg_state}, 32'd0);
    chk("hs_busy", {31'd0, busy}, 32'd0);

    // Frame 2: one byte every 20 cycles
    wr_q.delete();
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      rx_data  = gap_bytes[k];
      rx_valid = 1'b1;
      chk("gap_ready", {31'd0, rx_ready}, 32'd1);
      tick();
      rx_valid = 1'b0;
      repeat (19) tick();
      chk("gap_wr_count", wr_q.size(), 8 * (k + 1));
      byte_v = gap_bytes[k];
      for (int b = 0; b < 8; b++) exp_q.push_back({10'(8 * k + b), byte_v[b]});
    end
    compare_writes("gap_wr");

    // Frame 2 continued to 40 bytes, then reset mid-frame
    for (int i = 0; i < 37; i++) send_byte(8'h5A);
    repeat (4) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    tick();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rx_ready", {31'd0, rx_ready}, 32'd1);
    rst_n = 1'b1;
    wr_q.delete();
    start_cnt  = 0;
    accept_cnt = 0;

    // Frame 3: 97 bytes must not start the core; the 98th does
    for (int i = 0; i < 97; i++) send_byte(8'h80);
    repeat (12) tick();
    chk("f3_no_start", start_cnt, 0);
    chk("f3_wr_count97", wr_q.size(), 776);
    chk("f3_first_wr", {21'd0, wr_q[0]}, {21'd0, 10'd0, 1'b0});
    chk("f3_bit7_wr", {21'd0, wr_q[7]}, {21'd0, 10'd7, 1'b1});
    send_byte(8'h80);
    wait_start(60);
    tick();
    chk("f3_starts", start_cnt, 1);
    chk("f3_wr_count", wr_q.size(), 784);
    chk("f3_last_wr", {21'd0, wr_q[783]}, {21'd0, 10'd783, 1'b1});
    chk("f3_in_run", {30'd0, dbg_state}, 32'd2);

`ifdef SNN_WDOG_EN
    // Watchdog expiry with core_done never asserted
    n = 0;
    while (!res_valid && n < 300) begin
      tick();
      n++;
    end
    chk("wdog_cycles", n, 100);
    chk("wdog_res_valid", {31'd0, res_valid}, 32'd1);
    chk("wdog_digit", {28'd0, res_digit}, 32'hF);
    chk("wdog_err", {31'd0, res_err}, 32'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("wdog_hs_valid", {31'd0, res_valid}, 32'd0);
`else
    // No watchdog: RUN persists until core_done
    n = 0;
    repeat (1000) begin
      tick();
      n++;
    end
    chk("nowdog_res_valid", {31'd0, res_valid}, 32'd0);
    chk("nowdog_state", {30'd0, dbg_state}, 32'd2);
    chk("nowdog_busy", {31'd0, busy}, 32'd1);
    core_done  = 1'b1;
    core_digit = 4'd3;
    tick();
    core_done  = 1'b0;
    chk("nowdog_res_digit", {28'd0, res_digit}, 32'd3);
    chk("nowdog_res_err", {31'd0, res_err}, 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("nowdog_hs_valid", {31'd0, res_valid}, 32'd0);
`endif
    chk("end_rx_ready", {31'd0, rx_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
